// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite register slave: access mode, response codes
// and the write/read channel FSM states.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        BOTH  = 2'd2
    } operation;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_DATA,
        WR_WAIT_ADDR,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

endpackage

// File: rtl/axi4lite_regfile.sv
// NUM_REGS x DATA_WIDTH storage: byte-enabled synchronous write, combinational
// read, synchronous clear that overrides any write in the same cycle.
module axi4lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 we,
    input  logic [IDX_W-1:0]                     wr_idx,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH/8-1:0]              wr_strb,
    input  logic [IDX_W-1:0]                     rd_idx,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (clr) begin
            mem <= '0;
        end else if (we) begin
            for (int k = 0; k < DATA_WIDTH/8; k++) begin
                if (wr_strb[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];
    assign regs    = mem;

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave register file: independent write and read channel FSMs in
// front of a byte-strobed register array; illegal accesses complete with SLVERR.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int       ADDR_WIDTH = 8,
    parameter int       DATA_WIDTH = 32,
    parameter int       NUM_REGS   = 16,
    parameter operation MODE       = BOTH
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS);
    localparam bit CAN_WR = (MODE != READ);
    localparam bit CAN_RD = (MODE != WRITE);

    wr_state_e               wr_state;
    rd_state_e               rd_state;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]   cmt_addr;
    logic [DATA_WIDTH-1:0]   cmt_data;
    logic [STRB_W-1:0]       cmt_strb;
    logic                    cmt_fire, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Commit operands: whichever half arrived earlier comes from the latch.
    always_comb begin
        cmt_addr = AWADDR;
        cmt_data = WDATA;
        cmt_strb = WSTRB;
        cmt_fire = 1'b0;
        case (wr_state)
            WR_IDLE:      cmt_fire = aw_hs && w_hs;
            WR_WAIT_DATA: begin cmt_addr = awaddr_q; cmt_fire = w_hs; end
            WR_WAIT_ADDR: begin cmt_data = wdata_q; cmt_strb = wstrb_q; cmt_fire = aw_hs; end
            default:      cmt_fire = 1'b0;
        endcase
    end

    assign wr_ok = CAN_WR && ((cmt_addr >> OFFS) < LIMIT);
    assign rd_ok = CAN_RD && ((ARADDR >> OFFS) < LIMIT);

    axi4lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (ACLK),
        .clr     (ARESET),
        .we      (cmt_fire && wr_ok),
        .wr_idx  (IDX_W'(cmt_addr >> OFFS)),
        .wr_data (cmt_data),
        .wr_strb (cmt_strb),
        .rd_idx  (IDX_W'(ARADDR >> OFFS)),
        .rd_data (rd_data),
        .regs    (regs)
    );

    assign regs_q = regs;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (cmt_fire) begin
            wr_state <= WR_RESP;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b1;
            BRESP    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= AWADDR;
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        wr_state <= WR_WAIT_DATA;
                    end else if (w_hs) begin
                        wdata_q  <= WDATA;
                        wstrb_q  <= WSTRB;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b0;
                        wr_state <= WR_WAIT_ADDR;
                    end else begin
                        // also the first cycle out of reset, when READYs come up
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is sampled before any same-edge write lands, so it sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        RDATA    <= rd_ok ? rd_data : '0;
                        RRESP    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        rd_state <= RD_RESP;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule
